// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS function generator.
//  - waveform function codes carried on cfg_func and through the pipeline
//  - Galois LFSR tap mask / seed and the single-step helper
//  - midscale helper for offset-binary samples
//  - sine_mag: constant function used to build the quarter-wave sine ROM
package dds_pkg;

  localparam logic [2:0] FUNC_SQUARE = 3'd0;
  localparam logic [2:0] FUNC_SINE   = 3'd1;
  localparam logic [2:0] FUNC_TRI    = 3'd2;
  localparam logic [2:0] FUNC_SAW    = 3'd3;
  localparam logic [2:0] FUNC_NOISE  = 3'd4;
  localparam logic [2:0] FUNC_ARB    = 3'd5;
  localparam logic [2:0] FUNC_MID    = 3'd6;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // Advance the noise LFSR by one step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s[0]) begin
      return (s >> 1) ^ LFSR_TAPS;
    end else begin
      return s >> 1;
    end
  endfunction

  // Offset-binary zero level for a w-bit sample (w <= 16).
  function automatic logic [15:0] midscale(input int unsigned w);
    return 16'h0001 << (w - 1);
  endfunction

  // round((2^(ow-1)-1) * sin(pi/2 * idx / 2^aw)) evaluated with Q30 fixed
  // point Taylor series; only ever called with constant arguments to fill
  // the ROM, so no hardware is generated for the arithmetic.
  function automatic int sine_mag(input int idx, input int aw, input int ow);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint peak;
    x    = (64'sd3373259426 * longint'(idx)) >>> (aw + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 6; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    peak = (64'sd1 <<< (ow - 1)) - 64'sd1;
    return int'((sum * peak + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: registered full-wave sine built from a quarter-wave table.
//  The top two phase bits select the quadrant: bit 0 mirrors the table index,
//  bit 1 negates the magnitude around midscale.
// Ports:
//  clk, reset  clock and async active-high reset
//  en          sample register update enable
//  phase       top SIN_AW+2 bits of the phase accumulator
//  sample      offset-binary sine sample, one cycle after phase
module sine_quarter_rom
  import dds_pkg::*;
#(
  parameter int unsigned SIN_AW = 6,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [SIN_AW+1:0] phase,
  output logic [OUT_W-1:0]  sample
);

  localparam logic [OUT_W-1:0] MID  = OUT_W'(midscale(OUT_W));
  localparam logic [OUT_W-2:0] PEAK = {(OUT_W-1){1'b1}};

  logic [OUT_W-2:0]  rom [2**SIN_AW];
  logic [1:0]        quad;
  logic [SIN_AW-1:0] idx;
  logic [SIN_AW-1:0] idx_m;
  logic [OUT_W-2:0]  mag;
  logic [OUT_W-1:0]  sample_nxt;

  for (genvar g = 0; g < 2**SIN_AW; g++) begin : g_rom
    assign rom[g] = (OUT_W-1)'(sine_mag(g, SIN_AW, OUT_W));
  end

  // Quadrant decode and mirror/negate around midscale.
  always_comb begin
    quad  = phase[SIN_AW+1:SIN_AW];
    idx   = phase[SIN_AW-1:0];
    idx_m = idx;
    if (quad[0]) begin
      idx_m = (~idx) + {{(SIN_AW-1){1'b0}}, 1'b1};
    end else begin
      idx_m = idx;
    end
    // Mirrored index 0 would be entry 2^SIN_AW, i.e. the crest itself.
    if (quad[0] && (idx == {SIN_AW{1'b0}})) begin
      mag = PEAK;
    end else begin
      mag = rom[idx_m];
    end
    if (quad[1]) begin
      sample_nxt = MID - {1'b0, mag};
    end else begin
      sample_nxt = MID + {1'b0, mag};
    end
  end

  // Output register (stage 1 for the sine path).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= MID;
    end else if (en) begin
      sample <= sample_nxt;
    end
  end

endmodule

// File: rtl/dds_func_gen.sv
// dds_func_gen: DDS function generator (phase accumulator + waveform stage).
//  Configuration is staged in a pending register and applied only at a phase
//  wrap (or immediately when the accumulator is stopped), so the output never
//  switches function, frequency or amplitude mid-period.
//  Pipeline: acc -> stage 1 (wave / ROM / external RAM) -> stage 2 (amp, out).
// Ports:
//  clk, reset        clock and async active-high reset
//  en                accumulator advance enable
//  cfg_valid/ready   configuration handshake
//  cfg_func/ftw/amp  function code, tuning word, attenuation shift
//  arb_addr          address to external synchronous waveform RAM
//  arb_data          RAM read data, one cycle after arb_addr
//  arb_sel           active function is arbitrary
//  out, out_valid    sample and its qualifier (en delayed by two cycles)
module dds_func_gen
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SIN_AW  = 6,
  parameter int unsigned ARB_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_func,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_amp,
  output logic [ARB_AW-1:0]  arb_addr,
  input  logic [OUT_W-1:0]   arb_data,
  output logic               arb_sel,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  // Active and pending configuration
  logic [PHASE_W-1:0] acc;
  logic [2:0]         func;
  logic [PHASE_W-1:0] ftw;
  logic [1:0]         amp;
  logic               pending;
  logic [2:0]         pend_func;
  logic [PHASE_W-1:0] pend_ftw;
  logic [1:0]         pend_amp;
  logic [31:0]        lfsr;

  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] acc_nxt;
  logic               wrap;
  logic               apply;
  logic               accept;

  // Pipeline
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   wave;
  logic [OUT_W-1:0]   sine_q;
  logic [OUT_W-1:0]   s1_wave;
  logic [2:0]         s1_func;
  logic [1:0]         s1_amp;
  logic               en_d1;
  logic [OUT_W-1:0]   s2_wave;
  logic signed [OUT_W-1:0] amp_diff;
  logic signed [OUT_W-1:0] amp_shift;
  logic [OUT_W-1:0]   out_nxt;

  assign cfg_ready = ~pending;

  // Accumulator add, wrap detection and config apply/accept decisions.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, ftw};
    wrap    = en & acc_sum[PHASE_W];
    if (en) begin
      acc_nxt = acc_sum[PHASE_W-1:0];
    end else begin
      acc_nxt = acc;
    end
    // Pending is only set after the cycle it was accepted in, so a wrap in
    // the acceptance cycle cannot apply it.
    apply  = pending & (wrap | ~en);
    accept = cfg_valid & ~pending;
  end

  // Phase accumulator, RAM address and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= {PHASE_W{1'b0}};
      arb_addr  <= {ARB_AW{1'b0}};
      func      <= FUNC_MID;
      ftw       <= {PHASE_W{1'b0}};
      amp       <= 2'd0;
      arb_sel   <= 1'b0;
      pending   <= 1'b0;
      pend_func <= FUNC_MID;
      pend_ftw  <= {PHASE_W{1'b0}};
      pend_amp  <= 2'd0;
    end else begin
      acc      <= acc_nxt;
      // Tracks acc so RAM data lands in step with the stage-1 wave.
      arb_addr <= acc_nxt[PHASE_W-1 -: ARB_AW];
      if (apply) begin
        func    <= pend_func;
        ftw     <= pend_ftw;
        amp     <= pend_amp;
        arb_sel <= (pend_func == FUNC_ARB);
        pending <= 1'b0;
      end else if (accept) begin
        pend_func <= cfg_func;
        pend_ftw  <= cfg_ftw;
        pend_amp  <= cfg_amp;
        pending   <= 1'b1;
      end
    end
  end

  // Noise source, advanced once per enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Stage-1 arithmetic waveforms (sine and arbitrary come from ROM / RAM).
  always_comb begin
    p    = acc[PHASE_W-1 -: OUT_W];
    wave = MID;
    case (func)
      FUNC_SQUARE: wave = {OUT_W{~p[OUT_W-1]}};
      FUNC_TRI:    wave = p[OUT_W-1] ? ~{p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
      FUNC_SAW:    wave = p;
      FUNC_NOISE:  wave = lfsr[OUT_W-1:0];
      default:     wave = MID;
    endcase
  end

  sine_quarter_rom #(
    .SIN_AW (SIN_AW),
    .OUT_W  (OUT_W)
  ) u_sine (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .phase  (acc[PHASE_W-1 -: SIN_AW+2]),
    .sample (sine_q)
  );

  // Stage-2 source select and attenuation.
  always_comb begin
    case (s1_func)
      FUNC_SINE: s2_wave = sine_q;
      FUNC_ARB:  s2_wave = arb_data;
      default:   s2_wave = s1_wave;
    endcase
    // Offset-binary minus midscale is exactly the MSB-flipped value read as
    // signed; the shifted result stays in range, so flipping back re-adds mid.
    amp_diff  = $signed({~s2_wave[OUT_W-1], s2_wave[OUT_W-2:0]});
    amp_shift = amp_diff >>> s1_amp;
    out_nxt   = {~amp_shift[OUT_W-1], amp_shift[OUT_W-2:0]};
  end

  // Stage registers; func/amp travel with the sample so each one is coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_wave   <= MID;
      s1_func   <= FUNC_MID;
      s1_amp    <= 2'd0;
      en_d1     <= 1'b0;
      out_valid <= 1'b0;
      out       <= MID;
    end else begin
      en_d1     <= en;
      out_valid <= en_d1;
      if (en) begin
        s1_wave <= wave;
        s1_func <= func;
        s1_amp  <= amp;
      end
      if (en_d1) begin
        out <= out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dds_func_gen.sv
// Self-checking bench for dds_func_gen (PHASE_W=16, OUT_W=8, SIN_AW=6, ARB_AW=8).
// A behavioural model tracks phase, configuration and noise state per cycle,
// computes each sample directly from the waveform definitions and delays it
// two cycles; every cycle the DUT outputs are compared against the model.
module tb_dds_func_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_func;
  logic [15:0] cfg_ftw;
  logic [1:0]  cfg_amp;
  logic [7:0]  arb_addr;
  logic [7:0]  arb_data;
  logic        arb_sel;
  logic [7:0]  out;
  logic        out_valid;

  int vectors;
  int miscompares;

  dds_func_gen #(
    .PHASE_W (16),
    .OUT_W   (8),
    .SIN_AW  (6),
    .ARB_AW  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_func  (cfg_func),
    .cfg_ftw   (cfg_ftw),
    .cfg_amp   (cfg_amp),
    .arb_addr  (arb_addr),
    .arb_data  (arb_data),
    .arb_sel   (arb_sel),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous waveform RAM: contents are addr ^ 8'h5A.
  always @(posedge clk) arb_data <= arb_addr ^ 8'h5A;

  // Reference model state
  typedef struct {
    bit en;
    int smp;
    bit tol;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_acc;
  logic [2:0]  m_func;
  logic [15:0] m_ftw;
  logic [1:0]  m_amp;
  bit          m_pend;
  logic [2:0]  p_func;
  logic [15:0] p_ftw;
  logic [1:0]  p_amp;
  logic [31:0] m_lfsr;
  int          m_out;
  bit          m_out_tol;
  bit          m_valid;

  task automatic model_reset();
    ent_t z;
    m_acc = 16'h0; m_func = 3'd6; m_ftw = 16'h0; m_amp = 2'd0; m_pend = 1'b0;
    p_func = 3'd6; p_ftw = 16'h0; p_amp = 2'd0;
    m_lfsr = 32'h1; m_out = 128; m_out_tol = 1'b0; m_valid = 1'b0;
    z.en = 1'b0; z.smp = 128; z.tol = 1'b0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  // Sample for the current model phase, straight from the waveform rules.
  function automatic ent_t model_sample();
    ent_t r;
    int   p;
    int   w;
    int   d;
    real  v;
    p = int'(m_acc[15:8]);
    r.en = 1'b0;
    r.tol = 1'b0;
    case (m_func)
      3'd0: w = (p < 128) ? 255 : 0;
      3'd1: begin
        v = 128.0 + 127.0 * $sin(6.283185307179586 * real'(p) / 256.0);
        w = $rtoi(v + 0.5);
        r.tol = ((p % 64) != 0);  // crest, trough and zero crossings are exact
      end
      3'd2: w = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      3'd3: w = p;
      3'd4: w = int'(m_lfsr[7:0]);
      3'd5: w = p ^ 32'h5A;
      default: w = 128;
    endcase
    d = w - 128;
    r.smp = 128 + (d >>> m_amp);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int diff;
    bit ok;
    diff = int'(out) - m_out;
    ok = m_out_tol ? (diff >= -1 && diff <= 1) : (diff == 0);
    vectors++;
    assert (!$isunknown(out) && ok) else begin
      miscompares++;
      $error("FAIL out observed=%0h expected=%0h", out, m_out);
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, ~m_pend});
    chk("arb_sel",   {31'b0, arb_sel},   {31'b0, (m_func == 3'd5)});
    chk("arb_addr",  {24'b0, arb_addr},  {24'b0, m_acc[15:8]});
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    ent_t        s;
    logic [16:0] sum;
    bit          carry;
    bit          apply_c;
    bit          accept_c;
    s = model_sample();
    s.en = en;
    q.push_back(s);
    sum      = {1'b0, m_acc} + {1'b0, m_ftw};
    carry    = en && sum[16];
    apply_c  = m_pend && (!en || carry);
    accept_c = cfg_valid && !m_pend;
    if (en) begin
      m_acc = sum[15:0];
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 32'h8020_0003;
      else           m_lfsr = m_lfsr >> 1;
    end
    if (apply_c) begin
      m_func = p_func; m_ftw = p_ftw; m_amp = p_amp; m_pend = 1'b0;
    end else if (accept_c) begin
      p_func = cfg_func; p_ftw = cfg_ftw; p_amp = cfg_amp; m_pend = 1'b1;
    end
    if (q.size() > 2) void'(q.pop_front());
    if (q[0].en) begin
      m_out = q[0].smp;
      m_out_tol = q[0].tol;
    end
    m_valid = q[0].en;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input logic [2:0] f, input logic [15:0] w, input logic [1:0] a);
    cfg_valid = 1'b1; cfg_func = f; cfg_ftw = w; cfg_amp = a;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_func = 3'd0; cfg_ftw = 16'h0; cfg_amp = 2'd0;
    #1;
    async_reset();

    // Sawtooth at 1/256 of clock rate, configured while stopped
    run(2);
    send_cfg(3'd3, 16'h0100, 2'd0);
    tick();
    en = 1'b1;
    run(300);

    // Mid-period switch to square waits for the wrap
    send_cfg(3'd0, 16'h0100, 2'd0);
    run(400);
    send_cfg(3'd0, 16'h0100, 2'd1);
    run(520);
    send_cfg(3'd0, 16'h0100, 2'd3);
    run(520);

    // Sine, 64-sample period, with an en=0 hold in the middle
    send_cfg(3'd1, 16'h0400, 2'd0);
    run(150);
    en = 1'b0;
    run(6);
    en = 1'b1;
    run(70);

    // Noise, arbitrary, triangle, midscale codes
    send_cfg(3'd4, 16'h0777, 2'd2);
    run(120);
    send_cfg(3'd5, 16'h0300, 2'd0);
    run(200);
    send_cfg(3'd5, 16'h0500, 2'd1);
    run(150);
    send_cfg(3'd2, 16'h0123, 2'd0);
    run(300);
    send_cfg(3'd6, 16'h0800, 2'd0);
    run(100);
    send_cfg(3'd7, 16'h0800, 2'd2);
    run(60);

    // Reset mid-run, then ftw=0 never wraps so the pending config sits
    async_reset();
    send_cfg(3'd3, 16'h0200, 2'd1);
    run(20);
    en = 1'b0;
    tick();
    en = 1'b1;
    run(300);

    // Randomized configuration traffic with random enable gaps
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < 200; c++) begin
        en        = ($urandom_range(0, 9) != 0);
        cfg_valid = ($urandom_range(0, 15) == 0);
        cfg_func  = 3'($urandom_range(0, 7));
        cfg_ftw   = 16'($urandom_range(0, 16'h0FFF));
        cfg_amp   = 2'($urandom_range(0, 3));
        tick();
      end
    end
    cfg_valid = 1'b0;
    en = 1'b1;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
